// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file for the decode stage, with a per-entry
// pending scoreboard for the hazard unit and a multi-cycle bulk-clear sequencer.
module regfile_param #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              pend1,
   output logic              pend2,
   input  logic              clr_req,
   output logic              busy,
   output logic              clrStateDbg
);

   localparam int N = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clrState_t;

   clrState_t         state;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] mem [N];
   logic [N-1:0]      pending;

   logic writeOk;
   logic rsvOk;

   // clr_req/busy: a request is taken only on a cycle where busy is low; while busy is
   // high every request input (we, rsv_en, clr_req) is dropped rather than queued.
   assign writeOk = we && !busy && !((ZERO_REG0 != 0) && (waddr == '0));
   assign rsvOk   = rsv_en && !busy && !((ZERO_REG0 != 0) && (rsv_addr == '0));

   assign clrStateDbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mem[i[ADDR_W-1:0]] <= '0;
         end
         pending <= '0;
         state   <= IDLE;
         busy    <= 1'b0;
         idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (writeOk) begin
                  mem[waddr]     <= wdata;
                  pending[waddr] <= 1'b0;
               end
               // Issued after the write so a same-address reserve leaves the entry pending.
               if (rsvOk) begin
                  pending[rsv_addr] <= 1'b1;
               end
               if (clr_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  idx   <= '0;
               end
            end
            CLEAR: begin
               mem[idx]     <= '0;
               pending[idx] <= 1'b0;
               idx          <= idx + 1'b1;
               if (&idx) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rdata1 = mem[raddr1];
      if ((ZERO_REG0 != 0) && (raddr1 == '0)) begin
         rdata1 = '0;
      end else if ((BYPASS != 0) && we && !busy && (waddr == raddr1)) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = mem[raddr2];
      if ((ZERO_REG0 != 0) && (raddr2 == '0)) begin
         rdata2 = '0;
      end else if ((BYPASS != 0) && we && !busy && (waddr == raddr2)) begin
         rdata2 = wdata;
      end
   end

   // Pending flags deliberately show the pre-edge value; no forwarding here.
   assign pend1 = pending[raddr1];
   assign pend2 = pending[raddr2];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a vector table for read/write/scoreboard behaviour,
// then hand-written sequences for the bulk clear and a reset that aborts it.
module tb_regfile_param;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int N      = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata1;
   logic [DATA_W-1:0] rdata2;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              pend1;
   logic              pend2;
   logic              clr_req;
   logic              busy;
   logic              clrStateDbg;

   regfile_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1), .ZERO_REG0(1)
   ) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend1(pend1), .pend2(pend2),
      .clr_req(clr_req), .busy(busy), .clrStateDbg(clrStateDbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;
   logic [DATA_W-1:0] exp_q[$];

   typedef struct {
      logic              rst;
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] ra1;
      logic [ADDR_W-1:0] ra2;
      logic              rsv;
      logic [ADDR_W-1:0] rsvAddr;
      logic              chk;
      logic [DATA_W-1:0] e1;
      logic [DATA_W-1:0] e2;
      logic              ep1;
      logic              ep2;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2, input logic rs,
                               input logic [ADDR_W-1:0] ra, input logic c,
                               input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2,
                               input logic p1, input logic p2);
      vec_t v;
      v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.ra1 = a1; v.ra2 = a2;
      v.rsv = rs; v.rsvAddr = ra; v.chk = c; v.e1 = x1; v.e2 = x2; v.ep1 = p1; v.ep2 = p2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // driver tasks
   task automatic setIdle();
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
      rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
   endtask

   task automatic writeReg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      setIdle();
      we = 1'b1; waddr = a; wdata = d;
   endtask

   task automatic reserve(input logic [ADDR_W-1:0] a);
      @(negedge clk);
      setIdle();
      rsv_en = 1'b1; rsv_addr = a;
   endtask

   task automatic sweepZero(input string tag);
      for (int k = 0; k < N; k++) exp_q.push_back('0);
      for (int k = 0; k < N; k++) begin
         logic [DATA_W-1:0] e;
         raddr1 = k[ADDR_W-1:0];
         raddr2 = k[ADDR_W-1:0];
         #1;
         e = exp_q.pop_front();
         check($sformatf("%s rdata1[%0d]", tag, k), 32'(rdata1), 32'(e));
         check($sformatf("%s pend2[%0d]", tag, k), 32'(pend2), 32'd0);
      end
   endtask

   initial begin
      setIdle();

      vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vecs[1]  = mk(0, 0, 0, 16'h0000, 0, 15, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      vecs[2]  = mk(0, 0, 0, 16'h0000, 7, 9,  0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      vecs[3]  = mk(0, 1, 5, 16'hA5A5, 5, 6,  0, 0, 1, 16'hA5A5, 16'h0000, 0, 0);
      vecs[4]  = mk(0, 0, 0, 16'h0000, 5, 5,  0, 0, 1, 16'hA5A5, 16'hA5A5, 0, 0);
      vecs[5]  = mk(0, 1, 0, 16'hFFFF, 0, 0,  1, 0, 1, 16'h0000, 16'h0000, 0, 0);
      vecs[6]  = mk(0, 0, 0, 16'h0000, 0, 0,  0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      vecs[7]  = mk(0, 0, 0, 16'h0000, 5, 3,  1, 3, 1, 16'hA5A5, 16'h0000, 0, 0);
      vecs[8]  = mk(0, 0, 0, 16'h0000, 3, 3,  0, 0, 1, 16'h0000, 16'h0000, 1, 1);
      vecs[9]  = mk(0, 1, 3, 16'h0033, 5, 3,  0, 0, 1, 16'hA5A5, 16'h0033, 0, 1);
      vecs[10] = mk(0, 0, 0, 16'h0000, 3, 3,  0, 0, 1, 16'h0033, 16'h0033, 0, 0);
      vecs[11] = mk(0, 1, 3, 16'h0044, 3, 3,  1, 3, 1, 16'h0044, 16'h0044, 0, 0);
      vecs[12] = mk(0, 0, 0, 16'h0000, 3, 3,  0, 0, 1, 16'h0044, 16'h0044, 1, 1);
      vecs[13] = mk(0, 1, 7, 16'h0777, 9, 7,  1, 9, 1, 16'h0000, 16'h0777, 0, 0);
      vecs[14] = mk(0, 0, 0, 16'h0000, 9, 7,  0, 0, 1, 16'h0000, 16'h0777, 1, 0);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         setIdle();
         rst = vecs[i].rst; we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
         rsv_en = vecs[i].rsv; rsv_addr = vecs[i].rsvAddr;
         #1;
         if (vecs[i].chk) begin
            check($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(vecs[i].e1));
            check($sformatf("v%0d rdata2", i), 32'(rdata2), 32'(vecs[i].e2));
            check($sformatf("v%0d pend1", i), 32'(pend1), 32'(vecs[i].ep1));
            check($sformatf("v%0d pend2", i), 32'(pend2), 32'(vecs[i].ep2));
            check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
         end
      end

      // Bulk clear with dropped requests while busy.
      for (int k = 1; k < N; k++) writeReg(k[ADDR_W-1:0], 16'h1234);
      reserve(4);
      reserve(12);
      @(negedge clk);
      setIdle();
      clr_req = 1'b1;
      #1;
      check("clr accept busy", 32'(busy), 32'd0);
      for (int c = 0; c < N; c++) begin
         logic [DATA_W-1:0] e1;
         @(negedge clk);
         setIdle();
         raddr2 = c[ADDR_W-1:0];
         if (c == 0) begin
            raddr1 = 0; e1 = 16'h0000;
         end else if (c == 6) begin
            raddr1 = 15; e1 = 16'h1234;
         end else if (c == 10) begin
            raddr1 = 13; e1 = 16'h1234;
         end else begin
            raddr1 = 4'(c - 1); e1 = 16'h0000;
         end
         if (c == 5) begin
            we = 1'b1; waddr = 15; wdata = 16'hBEEF;
         end
         if (c == 7) begin
            rsv_en = 1'b1; rsv_addr = 13;
         end
         if (c == 8) clr_req = 1'b1;
         #1;
         check($sformatf("clr c%0d busy", c), 32'(busy), 32'd1);
         check($sformatf("clr c%0d state", c), 32'(clrStateDbg), 32'd1);
         check($sformatf("clr c%0d rdata1", c), 32'(rdata1), 32'(e1));
         check($sformatf("clr c%0d rdata2", c), 32'(rdata2), (c == 0) ? 32'h0 : 32'h1234);
         check($sformatf("clr c%0d pend1", c), 32'(pend1), 32'd0);
         check($sformatf("clr c%0d pend2", c), 32'(pend2), (c == 4 || c == 12) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      setIdle();
      #1;
      check("clr done busy", 32'(busy), 32'd0);
      sweepZero("after clr");
      @(negedge clk);
      setIdle();
      #1;
      check("clr not requeued", 32'(busy), 32'd0);

      // Reset aborting a clear part-way through.
      for (int k = 1; k < N; k++) writeReg(k[ADDR_W-1:0], 16'(16'h1000 + k));
      reserve(2);
      @(negedge clk);
      setIdle();
      clr_req = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         setIdle();
      end
      @(negedge clk);
      setIdle();
      rst = 1'b1;
      raddr1 = 10;
      #1;
      check("mid clr busy", 32'(busy), 32'd1);
      check("mid clr uncleared", 32'(rdata1), 32'h100A);
      @(negedge clk);
      setIdle();
      #1;
      check("abort busy", 32'(busy), 32'd0);
      sweepZero("after abort");

      @(negedge clk);
      setIdle();
      clr_req = 1'b1;
      begin
         int cnt;
         cnt = 0;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            setIdle();
            #1;
            if (busy) cnt++;
            else break;
         end
         check("reclr busy cycles", 32'(cnt), 32'd16);
         check("reclr ends idle", 32'(busy), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
